// File: rtl/manchester_tx.sv
// manchester_tx: FIFO-buffered Manchester serial transmitter.
// Framing: optional preamble cells, data cells, then idle gap cells.
// Ports: clk16x/rst_n clock and async active-low reset;
//   wrn/din write strobe (rising edge) and data;
//   tbre/full/level FIFO status; busy FSM active;
//   ovf dropped-write pulse; mdo/mdo_en serial line and driver enable.
module manchester_tx #(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PRE_BITS   = 0,
  parameter int GAP_BITS   = 1,
  parameter int MSB_FIRST  = 1,
  parameter int POLARITY   = 0
) (
  input  logic                            clk16x,
  input  logic                            rst_n,
  input  logic                            wrn,
  input  logic [DATA_W-1:0]               din,
  output logic                            tbre,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            busy,
  output logic                            ovf,
  output logic                            mdo,
  output logic                            mdo_en
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = $clog2(OVS);
  localparam int M1 = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
  localparam int BMAX = (M1 > GAP_BITS) ? M1 : GAP_BITS;
  localparam int BW = $clog2(BMAX+1);
  localparam logic POL = 1'(POLARITY);

  typedef enum logic [1:0] {
    S_IDLE, S_PRE, S_DATA, S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_wrn1;
  logic              r_wrn2;
  logic              r_ovf;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [LW-1:0]     r_level;
  logic [CW-1:0]     r_cell;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_sh;

  logic w_wr_evt;
  logic w_push;
  logic w_pop;
  logic w_cell_end;
  logic w_half;
  logic w_last;
  logic w_bit;
  logic w_cur;
  state_t w_first;

  assign w_wr_evt = r_wrn1 & ~r_wrn2;
  // full is the pre-pop value, so a same-cycle pop never rescues a write
  assign w_push   = w_wr_evt & ~full;

  assign tbre  = (r_level == '0);
  assign full  = (r_level == LW'(FIFO_DEPTH));
  assign level = r_level;
  assign busy  = (r_state != S_IDLE);
  assign ovf   = r_ovf;

  assign w_cell_end = (r_cell == CW'(OVS-1));
  assign w_half     = (r_cell >= CW'(OVS/2));
  assign w_cur = (MSB_FIRST != 0) ? r_sh[DATA_W-1] : r_sh[0];
  assign w_first = (PRE_BITS > 0) ? S_PRE : S_DATA;

  always_ff @(posedge clk16x or negedge rst_n) begin
    if (!rst_n) begin
      r_wrn1 <= 1'b1;
      r_wrn2 <= 1'b1;
    end else begin
      r_wrn1 <= wrn;
      r_wrn2 <= r_wrn1;
    end
  end

  always_ff @(posedge clk16x) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  always_ff @(posedge clk16x or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      r_ovf   <= w_wr_evt & full;
    end
  end

  always_ff @(posedge clk16x or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_last      = 1'b0;
    w_bit       = 1'b0;
    mdo         = 1'b0;
    mdo_en      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!tbre) begin
          w_pop       = 1'b1;
          w_state_nxt = w_first;
        end
      end
      S_PRE: begin
        mdo_en = 1'b1;
        // alternating preamble starting with 1
        w_bit  = ~r_bit[0];
        mdo    = w_bit ^ w_half ^ POL;
        w_last = (r_bit == BW'(PRE_BITS-1));
        if (w_cell_end && w_last) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        mdo_en = 1'b1;
        w_bit  = w_cur;
        mdo    = w_bit ^ w_half ^ POL;
        w_last = (r_bit == BW'(DATA_W-1));
        if (w_cell_end && w_last) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        mdo_en = 1'b1;
        w_last = (r_bit == BW'(GAP_BITS-1));
        if (w_cell_end && w_last) begin
          if (!tbre) begin
            w_pop       = 1'b1;
            w_state_nxt = w_first;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk16x or negedge rst_n) begin
    if (!rst_n) begin
      r_cell <= '0;
      r_bit  <= '0;
      r_sh   <= '0;
    end else if (r_state == S_IDLE) begin
      r_cell <= '0;
      r_bit  <= '0;
      if (w_pop) r_sh <= r_mem[r_rp];
    end else if (w_cell_end) begin
      r_cell <= '0;
      r_bit  <= w_last ? '0 : r_bit + BW'(1);
      if (r_state == S_DATA) begin
        if (MSB_FIRST != 0) r_sh <= r_sh << 1;
        else                r_sh <= r_sh >> 1;
      end
      if (w_pop) r_sh <= r_mem[r_rp];
    end else begin
      r_cell <= r_cell + CW'(1);
    end
  end

endmodule

// File: tb/tb_manchester_tx.sv
// tb_manchester_tx: directed + random checks of manchester_tx.
// Three instances cover default, preamble/LSB/inverted, and tiny configs.
module tb_manchester_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       wrn_a, wrn_b, wrn_c;
  logic [7:0] din_a, din_b;
  logic [0:0] din_c;
  logic tbre_a, full_a, busy_a, ovf_a, mdo_a, en_a;
  logic tbre_b, full_b, busy_b, ovf_b, mdo_b, en_b;
  logic tbre_c, full_c, busy_c, ovf_c, mdo_c, en_c;
  logic [2:0] level_a, level_b;
  logic [1:0] level_c;

  manchester_tx u_a (
    .clk16x(clk), .rst_n(rst_n), .wrn(wrn_a), .din(din_a),
    .tbre(tbre_a), .full(full_a), .level(level_a),
    .busy(busy_a), .ovf(ovf_a), .mdo(mdo_a), .mdo_en(en_a)
  );

  manchester_tx #(
    .PRE_BITS(4), .MSB_FIRST(0), .POLARITY(1)
  ) u_b (
    .clk16x(clk), .rst_n(rst_n), .wrn(wrn_b), .din(din_b),
    .tbre(tbre_b), .full(full_b), .level(level_b),
    .busy(busy_b), .ovf(ovf_b), .mdo(mdo_b), .mdo_en(en_b)
  );

  manchester_tx #(
    .OVS(4), .DATA_W(1), .GAP_BITS(1), .FIFO_DEPTH(2)
  ) u_c (
    .clk16x(clk), .rst_n(rst_n), .wrn(wrn_c), .din(din_c),
    .tbre(tbre_c), .full(full_c), .level(level_c),
    .busy(busy_c), .ovf(ovf_c), .mdo(mdo_c), .mdo_en(en_c)
  );

  int n_asrt = 0;
  int n_fail = 0;

  bit qa[$], qb[$], qc[$];
  bit eq[$];
  int ra = 0, rb = 0, rc = 0;
  bit pa = 0, pb = 0, pc = 0;
  int novf_a = 0;

  // line monitor: record driven mdo samples and count enable bursts
  always @(posedge clk) begin
    #1;
    if (en_a) begin qa.push_back(mdo_a); if (!pa) ra++; end
    if (en_b) begin qb.push_back(mdo_b); if (!pb) rb++; end
    if (en_c) begin qc.push_back(mdo_c); if (!pc) rc++; end
    pa = en_a; pb = en_b; pc = en_c;
    if (ovf_a) novf_a++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int inst, input logic [31:0] d);
    case (inst)
      0: begin din_a = d[7:0]; wrn_a = 1'b0; end
      1: begin din_b = d[7:0]; wrn_b = 1'b0; end
      default: begin din_c = d[0:0]; wrn_c = 1'b0; end
    endcase
    tick();
    case (inst)
      0: wrn_a = 1'b1;
      1: wrn_b = 1'b1;
      default: wrn_c = 1'b1;
    endcase
    tick();
    tick();
  endtask

  function automatic bit busy_of(input int inst);
    case (inst)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic wait_idle(input string tag, input int inst,
                           input int max);
    int n = 0;
    repeat (2) tick();
    while (busy_of(inst) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, (n < max), 1);
  endtask

  // reference waveform: one sample per clock while the line is driven
  task automatic add_frame(input int pre, input int dw, input int ovs,
                           input int gap, input int msb, input int pol,
                           input logic [31:0] d);
    bit b;
    bit p;
    int idx;
    p = (pol != 0);
    for (int c = 0; c < pre + dw; c++) begin
      if (c < pre) begin
        b = (c % 2 == 0);
      end else begin
        idx = (msb != 0) ? (dw - 1 - (c - pre)) : (c - pre);
        b = d[idx];
      end
      repeat (ovs / 2) eq.push_back(b ^ p);
      repeat (ovs / 2) eq.push_back(~b ^ p);
    end
    repeat (gap * ovs) eq.push_back(1'b0);
  endtask

  task automatic check_stream(input string tag, input int inst,
                              input int exp_runs);
    bit obs[$];
    int runs;
    int nbad = 0;
    case (inst)
      0: begin obs = qa; runs = ra; qa = {}; ra = 0; end
      1: begin obs = qb; runs = rb; qb = {}; rb = 0; end
      default: begin obs = qc; runs = rc; qc = {}; rc = 0; end
    endcase
    chk({tag, "_len"}, obs.size(), eq.size());
    for (int i = 0; i < obs.size() && i < eq.size(); i++)
      if (obs[i] !== eq[i]) nbad++;
    chk({tag, "_bits"}, nbad, 0);
    chk({tag, "_runs"}, runs, exp_runs);
    eq = {};
  endtask

  logic [31:0] d;

  initial begin
    rst_n = 1'b0;
    wrn_a = 1'b1; wrn_b = 1'b1; wrn_c = 1'b1;
    din_a = '0; din_b = '0; din_c = '0;
    repeat (3) tick();
    chk("rst_tbre", tbre_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_level", level_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_mdo", mdo_a, 0);
    chk("rst_mdo_en", en_a, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // single A5 frame with latency and duration checks
    din_a = 8'hA5;
    wrn_a = 1'b0;
    tick();
    wrn_a = 1'b1;
    tick();
    chk("lat_k_tbre", tbre_a, 1);
    chk("lat_k_level", level_a, 0);
    tick();
    chk("lat_k1_tbre", tbre_a, 0);
    chk("lat_k1_level", level_a, 1);
    chk("lat_k1_en", en_a, 0);
    tick();
    chk("lat_k2_en", en_a, 1);
    chk("lat_k2_busy", busy_a, 1);
    chk("lat_k2_tbre", tbre_a, 1);
    repeat (143) tick();
    chk("a5_last_busy", busy_a, 1);
    tick();
    chk("a5_end_busy", busy_a, 0);
    chk("a5_end_en", en_a, 0);
    add_frame(0, 8, 16, 1, 1, 0, 32'hA5);
    check_stream("a5", 0, 1);

    // isolated random frames
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      wr(0, d);
      wait_idle("rnd", 0, 400);
      add_frame(0, 8, 16, 1, 1, 0, d);
    end
    check_stream("rnd", 0, 3);

    // overflow: one frame in flight, then six writes into 4 slots
    d = $urandom;
    wr(0, d);
    add_frame(0, 8, 16, 1, 1, 0, d);
    novf_a = 0;
    for (int i = 1; i <= 6; i++) wr(0, i);
    chk("ovf_full", full_a, 1);
    chk("ovf_level", level_a, 4);
    tick();
    chk("ovf_pulses", novf_a, 2);
    for (int i = 1; i <= 4; i++) add_frame(0, 8, 16, 1, 1, 0, i);
    wait_idle("b2b", 0, 2000);
    check_stream("b2b", 0, 1);

    // reset mid-frame with two words queued
    wr(0, $urandom);
    wr(0, $urandom);
    wr(0, $urandom);
    chk("mid_level", level_a, 2);
    begin
      int n = 0;
      while (qa.size() < 60 && n < 200) begin tick(); n++; end
      chk("mid_reach60", (n < 200), 1);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_mdo", mdo_a, 0);
    chk("arst_en", en_a, 0);
    chk("arst_level", level_a, 0);
    chk("arst_tbre", tbre_a, 1);
    chk("arst_busy", busy_a, 0);
    tick();
    tick();
    rst_n = 1'b1;
    qa = {}; ra = 0;
    repeat (500) tick();
    chk("post_rst_quiet", qa.size(), 0);
    chk("post_rst_busy", busy_a, 0);
    d = $urandom;
    wr(0, d);
    wait_idle("post", 0, 400);
    add_frame(0, 8, 16, 1, 1, 0, d);
    check_stream("post", 0, 1);

    // preamble, LSB first, inverted polarity
    wr(1, 32'h80);
    wait_idle("pre80", 1, 600);
    add_frame(4, 8, 16, 1, 0, 1, 32'h80);
    d = $urandom;
    wr(1, d);
    wait_idle("prernd", 1, 600);
    add_frame(4, 8, 16, 1, 0, 1, d);
    check_stream("pre", 1, 2);

    // tiny config: two 8-cycle frames back to back
    d = $urandom;
    wr(2, d);
    wr(2, d >> 1);
    wait_idle("tiny", 2, 100);
    add_frame(0, 1, 4, 1, 1, 0, d);
    add_frame(0, 1, 4, 1, 1, 0, d >> 1);
    check_stream("tiny", 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
